// File: rtl/sgpu_multi_fetch.sv
// Multi-channel sequential-read fetch engine: each channel streams DW-word
// bursts from ICB memory into its own FWFT FIFO, one bus read at a time.
module sgpu_multi_fetch #(
   parameter int NUM_CH     = 2,
   parameter int DW         = 64,
   parameter int AW         = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH-1:0]       abort,
   input  logic [NUM_CH*AW-1:0]    cfg_base,
   input  logic [NUM_CH*LEN_W-1:0] cfg_words,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       done,
   output logic [NUM_CH-1:0]       err,
   output logic                    o_icb_cmd_vld,
   input  logic                    o_icb_cmd_rdy,
   output logic                    o_icb_cmd_read,
   output logic [AW-1:0]           o_icb_cmd_addr,
   output logic [DW-1:0]           o_icb_cmd_wdata,
   output logic [DW/8-1:0]         o_icb_cmd_wmask,
   input  logic                    o_icb_rsp_vld,
   output logic                    o_icb_rsp_rdy,
   input  logic [DW-1:0]           o_icb_rsp_rdata,
   input  logic                    o_icb_rsp_err,
   output logic [NUM_CH-1:0]       s_vld,
   input  logic [NUM_CH-1:0]       s_rdy,
   output logic [NUM_CH*DW-1:0]    s_data
);

   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [AW-1:0] STEP = AW'(DW / 8);

   typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;

   state_t          state;
   logic [CW-1:0]   grant, last, pick, idx;
   logic            found, discard, rsp_live;
   logic [AW-1:0]   cmd_addr;

   logic [AW-1:0]    addr_q [NUM_CH];
   logic [LEN_W-1:0] remain [NUM_CH];
   logic [DW-1:0]    mem    [NUM_CH][FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr [NUM_CH];
   logic [PW-1:0]    rd_ptr [NUM_CH];
   logic [PW:0]      count  [NUM_CH];
   logic [NUM_CH-1:0] elig, push, fail, pop;

   assign o_icb_cmd_vld   = (state == CMD);
   assign o_icb_cmd_read  = 1'b1;
   assign o_icb_cmd_addr  = cmd_addr;
   assign o_icb_cmd_wdata = '0;
   assign o_icb_cmd_wmask = '0;
   assign o_icb_rsp_rdy   = (state == RSP);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_stream
      assign s_vld[g]             = (count[g] != '0);
      assign s_data[g*DW +: DW]   = mem[g][rd_ptr[g]];
   end

   // Round-robin search begins one past the last granted channel.
   always_comb begin
      found = 1'b0;
      pick  = last;
      idx   = '0;
      for (int i = 0; i < NUM_CH; i++)
         elig[i] = busy[i] && (remain[i] != '0) && (count[i] != (PW+1)'(FIFO_DEPTH));
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = CW'((int'(last) + k) % NUM_CH);
         if (!found && elig[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   // A response for an aborted transfer is still handshaken but never lands.
   always_comb begin
      rsp_live = (state == RSP) && o_icb_rsp_vld && !discard && !abort[grant];
      for (int i = 0; i < NUM_CH; i++) begin
         push[i] = rsp_live && !o_icb_rsp_err && (grant == CW'(i));
         fail[i] = rsp_live &&  o_icb_rsp_err && (grant == CW'(i));
         pop[i]  = s_vld[i] && s_rdy[i];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         last     <= CW'(NUM_CH - 1);
         discard  <= 1'b0;
         cmd_addr <= '0;
      end else begin
         case (state)
            IDLE: if (found) begin
               grant    <= pick;
               last     <= pick;
               cmd_addr <= addr_q[pick];
               discard  <= abort[pick];
               state    <= CMD;
            end
            CMD: begin
               if (abort[grant]) discard <= 1'b1;
               if (o_icb_cmd_rdy) state <= RSP;
            end
            RSP: begin
               if (abort[grant]) discard <= 1'b1;
               if (o_icb_rsp_vld) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            busy[i]   <= 1'b0;
            done[i]   <= 1'b0;
            err[i]    <= 1'b0;
            addr_q[i] <= '0;
            remain[i] <= '0;
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            done[i] <= 1'b0;
            if (abort[i]) begin
               busy[i]   <= 1'b0;
               wr_ptr[i] <= '0;
               rd_ptr[i] <= '0;
               count[i]  <= '0;
            end else begin
               if (start[i] && !busy[i]) begin
                  err[i] <= 1'b0;
                  if (cfg_words[i*LEN_W +: LEN_W] == '0) begin
                     done[i] <= 1'b1;
                  end else begin
                     busy[i]   <= 1'b1;
                     addr_q[i] <= cfg_base[i*AW +: AW];
                     remain[i] <= cfg_words[i*LEN_W +: LEN_W];
                  end
               end
               if (push[i]) begin
                  wr_ptr[i] <= wr_ptr[i] + PW'(1);
                  addr_q[i] <= addr_q[i] + STEP;
                  remain[i] <= remain[i] - LEN_W'(1);
                  if (remain[i] == LEN_W'(1)) begin
                     done[i] <= 1'b1;
                     busy[i] <= 1'b0;
                  end
               end
               if (fail[i]) begin
                  err[i]  <= 1'b1;
                  busy[i] <= 1'b0;
               end
               if (pop[i]) rd_ptr[i] <= rd_ptr[i] + PW'(1);
               if (push[i] && !pop[i])      count[i] <= count[i] + (PW+1)'(1);
               else if (pop[i] && !push[i]) count[i] <= count[i] - (PW+1)'(1);
            end
         end
      end
   end

   // NOTE: FIFO storage has no reset; the pointers and count alone decide
   // what is valid, so clearing the array would only cost logic.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++)
         if (push[i]) mem[i][wr_ptr[i]] <= o_icb_rsp_rdata;
   end

endmodule

// File: tb/tb_sgpu_multi_fetch.sv
// Self-checking bench for sgpu_multi_fetch: ICB memory responder, address
// and per-channel data scoreboards, a vector table plus corner sequences.
module tb_sgpu_multi_fetch;

   localparam int NUM_CH = 2, DW = 64, AW = 32, FIFO_DEPTH = 16, LEN_W = 16;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_CH-1:0]       start, abort, busy, done, err, s_vld, s_rdy;
   logic [NUM_CH*AW-1:0]    cfg_base;
   logic [NUM_CH*LEN_W-1:0] cfg_words;
   logic                    cmd_vld, cmd_rdy, cmd_read, rsp_vld, rsp_rdy, rsp_err;
   logic [AW-1:0]           cmd_addr;
   logic [DW-1:0]           cmd_wdata, rsp_rdata;
   logic [DW/8-1:0]         cmd_wmask;
   logic [NUM_CH*DW-1:0]    s_data;

   sgpu_multi_fetch #(.NUM_CH(NUM_CH), .DW(DW), .AW(AW), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_base(cfg_base), .cfg_words(cfg_words),
      .busy(busy), .done(done), .err(err),
      .o_icb_cmd_vld(cmd_vld), .o_icb_cmd_rdy(cmd_rdy), .o_icb_cmd_read(cmd_read),
      .o_icb_cmd_addr(cmd_addr), .o_icb_cmd_wdata(cmd_wdata), .o_icb_cmd_wmask(cmd_wmask),
      .o_icb_rsp_vld(rsp_vld), .o_icb_rsp_rdy(rsp_rdy), .o_icb_rsp_rdata(rsp_rdata),
      .o_icb_rsp_err(rsp_err),
      .s_vld(s_vld), .s_rdy(s_rdy), .s_data(s_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0, n_fail = 0;
   int n_cmd = 0;
   int done_cnt[NUM_CH] = '{default: 0};
   int done_cyc[NUM_CH] = '{default: 0};
   logic [AW-1:0] exp_addr[$];
   logic [DW-1:0] exp_data[NUM_CH][$];
   bit            err_en = 1'b0;
   logic [AW-1:0] err_addr = '0;
   int            rsp_delay = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Memory contents: word index relative to 0x1000, offset by 0xA0.
   function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
      logic [31:0] d;
      d = (a - 32'h1000) >> 3;
      return {32'h0, d} + 64'hA0;
   endfunction

   task automatic expect_burst(input int ch, input logic [AW-1:0] base, input int words);
      for (int k = 0; k < words; k++) begin
         exp_addr.push_back(base + AW'(8 * k));
         exp_data[ch].push_back(data_of(base + AW'(8 * k)));
      end
   endtask

   task automatic cfg(input int ch, input logic [AW-1:0] base, input int words);
      cfg_base[ch*AW +: AW]        = base;
      cfg_words[ch*LEN_W +: LEN_W] = LEN_W'(words);
   endtask

   task automatic pulse_start(input int ch);
      start[ch] = 1'b1;
      @(posedge clk); #1;
      start[ch] = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_drained(input string name, input int ch, input int d0);
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 400; t++) begin
         if (!busy[ch] && exp_data[ch].size() == 0 && exp_addr.size() == 0 && done_cnt[ch] != d0) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check(name, ok, 1);
   endtask

   // ICB memory responder; compares each accepted command with the address scoreboard.
   initial begin
      logic [AW-1:0] a;
      rsp_vld = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst && cmd_vld && cmd_rdy) begin
            a = cmd_addr;
            n_cmd++;
            check("cmd_fields", {cmd_read, cmd_wdata == '0, cmd_wmask == '0}, 3'b111);
            check("cmd_expected", exp_addr.size() != 0, 1);
            if (exp_addr.size() != 0) check("cmd_addr", a, exp_addr.pop_front());
            @(posedge clk); #1;
            repeat (rsp_delay) begin @(posedge clk); #1; end
            rsp_vld   = 1'b1;
            rsp_err   = err_en && (a == err_addr);
            rsp_rdata = rsp_err ? 64'hDEAD_BEEF_DEAD_BEEF : data_of(a);
            for (int t = 0; t < 64; t++) begin
               @(negedge clk);
               if (rsp_rdy) break;
            end
            check("rsp_accepted", rsp_rdy, 1);
            @(posedge clk); #1;
            rsp_vld = 1'b0;
            rsp_err = 1'b0;
         end
      end
   end

   // Stream and done monitor, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (done[i]) begin
                  done_cnt[i]++;
                  done_cyc[i] = cyc;
               end
               if (s_vld[i] && s_rdy[i] && !abort[i]) begin
                  check($sformatf("stream%0d_expected", i), exp_data[i].size() != 0, 1);
                  if (exp_data[i].size() != 0)
                     check($sformatf("stream%0d_data", i), s_data[i*DW +: DW], exp_data[i].pop_front());
               end
            end
         end
      end
   end

   typedef struct {
      int            ch;
      logic [AW-1:0] base;
      int            words;
      bit            exp_busy;
      int            exp_lat;
      int            exp_done;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int d0, d1, n0, c0;
      bit ok;

      vecs[0] = '{0, 32'h0000_1000, 4, 1'b1, 13, 1};
      vecs[1] = '{1, 32'h0000_2000, 0, 1'b0,  1, 1};
      vecs[2] = '{1, 32'hFFFF_FFF8, 2, 1'b1,  7, 1};
      vecs[3] = '{0, 32'h0000_4000, 1, 1'b1,  4, 1};
      vecs[4] = '{1, 32'h0000_5008, 5, 1'b1, 16, 1};

      rst = 1'b1; start = '0; abort = '0; cfg_base = '0; cfg_words = '0;
      s_rdy = '1; cmd_rdy = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_s_vld", s_vld, 0);
      check("rst_cmd_vld", cmd_vld, 0);
      check("rst_rsp_rdy", rsp_rdy, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;

      // Single-channel transfers: 3 cycles per word plus one cycle to go busy.
      for (int r = 0; r < 5; r++) begin
         d0 = done_cnt[vecs[r].ch];
         expect_burst(vecs[r].ch, vecs[r].base, vecs[r].words);
         cfg(vecs[r].ch, vecs[r].base, vecs[r].words);
         c0 = cyc;
         pulse_start(vecs[r].ch);
         check($sformatf("row%0d_busy", r), busy[vecs[r].ch], vecs[r].exp_busy);
         wait_drained($sformatf("row%0d_complete", r), vecs[r].ch, d0);
         repeat (2) begin @(posedge clk); #1; end
         check($sformatf("row%0d_done", r), done_cnt[vecs[r].ch] - d0, vecs[r].exp_done);
         check($sformatf("row%0d_latency", r), done_cyc[vecs[r].ch] - c0, vecs[r].exp_lat);
         check($sformatf("row%0d_err", r), err[vecs[r].ch], 0);
      end

      // Round-robin alternation from a fresh reset (channel 0 first).
      do_reset();
      d0 = done_cnt[0]; d1 = done_cnt[1];
      for (int k = 0; k < 3; k++) begin
         exp_addr.push_back(32'h1000 + AW'(8 * k));
         exp_addr.push_back(32'h2000 + AW'(8 * k));
         exp_data[0].push_back(data_of(32'h1000 + AW'(8 * k)));
         exp_data[1].push_back(data_of(32'h2000 + AW'(8 * k)));
      end
      cfg(0, 32'h1000, 3);
      cfg(1, 32'h2000, 3);
      start = 2'b11;
      @(posedge clk); #1 start = '0;
      wait_drained("rr_ch0_complete", 0, d0);
      wait_drained("rr_ch1_complete", 1, d1);
      repeat (2) begin @(posedge clk); #1; end
      check("rr_done0", done_cnt[0] - d0, 1);
      check("rr_done1", done_cnt[1] - d1, 1);

      // FIFO back-pressure: 16 words fill ch0, then the rest after draining.
      s_rdy[0] = 1'b0;
      d0 = done_cnt[0]; n0 = n_cmd;
      expect_burst(0, 32'h8000, 20);
      cfg(0, 32'h8000, 20);
      pulse_start(0);
      repeat (80) begin @(posedge clk); #1; end
      check("full_fetches", n_cmd - n0, 16);
      check("full_bus_idle", cmd_vld, 0);
      check("full_busy", busy[0], 1);
      s_rdy[0] = 1'b1;
      wait_drained("full_complete", 0, d0);
      check("full_total_fetches", n_cmd - n0, 20);
      check("full_done", done_cnt[0] - d0, 1);

      // Bus error on the second word of ch1.
      err_en = 1'b1; err_addr = 32'h6008;
      s_rdy[1] = 1'b0;
      d1 = done_cnt[1];
      exp_addr.push_back(32'h6000);
      exp_addr.push_back(32'h6008);
      exp_data[1].push_back(data_of(32'h6000));
      cfg(1, 32'h6000, 3);
      pulse_start(1);
      ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
         if (!busy[1]) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      check("err_busy_cleared", ok, 1);
      repeat (5) begin @(posedge clk); #1; end
      check("err_flag", err[1], 1);
      check("err_no_done", done_cnt[1] - d1, 0);
      check("err_no_more_fetch", exp_addr.size(), 0);
      check("err_word_kept", s_vld[1], 1);
      s_rdy[1] = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      check("err_word_popped", exp_data[1].size(), 0);
      check("err_sticky", err[1], 1);
      err_en = 1'b0;
      d1 = done_cnt[1];
      cfg(1, 32'h0, 0);
      pulse_start(1);
      check("err_cleared_by_start", err[1], 0);
      @(posedge clk); #1;
      check("zero_len_done", done_cnt[1] - d1, 1);

      // Abort while the response is outstanding.
      rsp_delay = 3;
      d0 = done_cnt[0]; n0 = n_cmd;
      exp_addr.push_back(32'h3000);
      cfg(0, 32'h3000, 4);
      pulse_start(0);
      for (int t = 0; t < 20; t++) begin
         if (rsp_rdy) break;
         @(posedge clk); #1;
      end
      check("abort_in_rsp", rsp_rdy, 1);
      abort[0] = 1'b1;
      @(posedge clk); #1 abort[0] = 1'b0;
      repeat (20) begin @(posedge clk); #1; end
      check("abort_busy", busy[0], 0);
      check("abort_fifo_empty", s_vld[0], 0);
      check("abort_no_err", err[0], 0);
      check("abort_no_done", done_cnt[0] - d0, 0);
      check("abort_one_fetch", n_cmd - n0, 1);
      check("abort_rsp_consumed", rsp_rdy, 0);
      rsp_delay = 0;

      // Abort flushes words already queued.
      s_rdy[0] = 1'b0;
      d0 = done_cnt[0];
      expect_burst(0, 32'h3100, 3);
      cfg(0, 32'h3100, 3);
      pulse_start(0);
      for (int t = 0; t < 100; t++) begin
         if (!busy[0]) break;
         @(posedge clk); #1;
      end
      repeat (2) begin @(posedge clk); #1; end
      check("flush_pre_vld", s_vld[0], 1);
      check("flush_pre_done", done_cnt[0] - d0, 1);
      abort[0] = 1'b1;
      @(posedge clk); #1 abort[0] = 1'b0;
      exp_data[0].delete();
      check("flush_empty", s_vld[0], 0);
      s_rdy[0] = 1'b1;

      // Abort and start together act as abort only.
      n0 = n_cmd;
      cfg(1, 32'h3200, 3);
      start[1] = 1'b1; abort[1] = 1'b1;
      @(posedge clk); #1 start[1] = 1'b0; abort[1] = 1'b0;
      check("abort_start_busy", busy[1], 0);
      repeat (10) begin @(posedge clk); #1; end
      check("abort_start_no_fetch", n_cmd - n0, 0);

      // Reset in the middle of a stalled command.
      cmd_rdy = 1'b0;
      cfg(0, 32'h7000, 2);
      pulse_start(0);
      for (int t = 0; t < 10; t++) begin
         if (cmd_vld) break;
         @(posedge clk); #1;
      end
      check("stall_cmd_vld", cmd_vld, 1);
      repeat (3) begin @(posedge clk); #1; end
      check("stall_cmd_held", cmd_vld, 1);
      check("stall_addr_stable", cmd_addr, 32'h7000);
      n0 = n_cmd;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_cmd_vld", cmd_vld, 0);
      check("midrst_busy", busy, 0);
      check("midrst_rsp_rdy", rsp_rdy, 0);
      rst = 1'b0; cmd_rdy = 1'b1;
      repeat (10) begin @(posedge clk); #1; end
      check("midrst_bus_quiet", n_cmd - n0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, failures=%0d", n_fail);
      $fatal(1);
   end

endmodule
